// File: rtl/helen_pkg.sv
// helen_pkg
// Shared constants for the on-chip RAM arbiter: RAM geometry, port indices
// and the saturating burst-run increment used by the arbitration state.
package helen_pkg;

  localparam int HELEN_RAM_ADDR_W = 13;
  localparam int HELEN_RAM_DATA_W = 32;
  localparam int HELEN_RAM_WORDS  = 8192;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // The run counter is 4 bits and sticks at 15 rather than wrapping, so a
  // long uncontended stream never looks like a fresh burst.
  function automatic logic [3:0] run_next(input logic [3:0] r);
    return (r == 4'hF) ? r : r + 4'd1;
  endfunction

endpackage

// File: rtl/helen_rr_pick2.sv
// helen_rr_pick2
// Combinational two-way round-robin grant with a bounded burst length.
// Ports:
//   req0, req1     : port requests
//   owner          : port that received the most recent grant
//   run            : consecutive grants given to owner
//   freeze         : blocks every grant while high
//   grant0, grant1 : one-hot (or zero) grant for this cycle
module helen_rr_pick2
  import helen_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic       req0,
  input  logic       req1,
  input  logic       owner,
  input  logic [3:0] run,
  input  logic       freeze,
  output logic       grant0,
  output logic       grant1
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  logic sel;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    sel    = owner;
    if (!freeze) begin
      if (req0 && req1) begin
        // Owner keeps the RAM until it has used up its burst allowance.
        sel    = (run < BURST_LIM) ? owner : ~owner;
        grant0 = (sel == PORT_CPU);
        grant1 = (sel == PORT_DMA);
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

endmodule

// File: rtl/helen_onchip_arbiter.sv
// helen_onchip_arbiter
// Shares the single-port on-chip RAM between two Avalon-MM masters
// (port 0 = Nios data master, port 1 = telemetry/DMA master). One access is
// accepted per cycle; reads return one cycle after acceptance.
// Ports:
//   clk, reset        : system clock, async active-high reset
//   freeze            : suppresses new grants (in-flight read still returns)
//   m0_* / m1_*       : Avalon-MM slave side for each master
//   ram_*             : RAM slave pins; ram_readdata comes back from the RAM
module helen_onchip_arbiter
  import helen_pkg::*;
#(
  parameter int ADDR_W    = HELEN_RAM_ADDR_W,
  parameter int DATA_W    = HELEN_RAM_DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic       req0, req1;
  logic       grant0, grant1;
  logic       owner;
  logic [3:0] run;
  logic       rd_pend;
  logic       rd_own;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Reset is folded into freeze so nothing reaches the RAM while it is held.
  helen_rr_pick2 #(.BURST_MAX(BURST_MAX)) u_pick (
    .req0   (req0),
    .req1   (req1),
    .owner  (owner),
    .run    (run),
    .freeze (freeze | reset),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_write      = 1'b0;
    if (grant0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
      ram_write      = m0_write;
    end else if (grant1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      ram_write      = m1_write;
    end
  end

  assign ram_chipselect = grant0 | grant1;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= PORT_CPU;
      run     <= 4'd0;
      rd_pend <= 1'b0;
      rd_own  <= PORT_CPU;
    end else begin
      // read|write together counts as a write, so only a pure read returns data.
      rd_pend <= (grant0 & ~m0_write) | (grant1 & ~m1_write);
      rd_own  <= grant1 ? PORT_DMA : PORT_CPU;
      if (grant0 | grant1) begin
        if ((grant1 ? PORT_DMA : PORT_CPU) == owner) begin
          run <= run_next(run);
        end else begin
          owner <= grant1 ? PORT_DMA : PORT_CPU;
          run   <= 4'd1;
        end
      end
    end
  end

  // RAM output is unregistered on our side: route it straight to the owner.
  assign m0_readdatavalid = rd_pend & (rd_own == PORT_CPU);
  assign m1_readdatavalid = rd_pend & (rd_own == PORT_DMA);
  assign m0_readdata      = m0_readdatavalid ? ram_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? ram_readdata : '0;

endmodule

// File: tb/tb_helen_onchip_arbiter.sv
module tb_helen_onchip_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  helen_onchip_arbiter #(.ADDR_W(13), .DATA_W(32), .BURST_MAX(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .freeze           (freeze),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .ram_address      (ram_address),
    .ram_byteenable   (ram_byteenable),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_writedata    (ram_writedata),
    .ram_clken        (ram_clken),
    .ram_readdata     (ram_readdata)
  );

  // RAM model: registered address, one-cycle read, byte-lane writes.
  logic [31:0] mem [0:8191];
  logic [31:0] rd_q = '0;
  assign ram_readdata = rd_q;

  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        rd_q <= mem[ram_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [12:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
  endtask

  initial begin
    int g, prev;
    for (int a = 0; a < 8192; a++) mem[a] = 32'hC0DE0000 | a;

    // reset with a request present
    reset  = 1'b1;
    freeze = 1'b0;
    drive0(1, 0, 13'h0010, 4'hF, 32'h0);
    drive1(0, 0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rd0", m0_readdata, 0);
    chk("rst_clken", ram_clken, 1);
    next_cycle();
    reset = 1'b0;

    // port 0 write then read back
    drive0(0, 1, 13'h0010, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr0_wait", m0_waitrequest, 0);
    chk("wr0_ramwr", ram_write, 1);
    chk("wr0_addr", ram_address, 13'h0010);
    chk("wr0_data", ram_writedata, 32'hDEADBEEF);
    next_cycle();
    drive0(1, 0, 13'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("rd0_wait", m0_waitrequest, 0);
    chk("rd0_ramwr", ram_write, 0);
    next_cycle();
    drive0(0, 0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rd0_rdv", m0_readdatavalid, 1);
    chk("rd0_data", m0_readdata, 32'hDEADBEEF);
    chk("rd0_m1rdv", m1_readdatavalid, 0);
    chk("rd0_m1data", m1_readdata, 0);
    next_cycle();

    // port 1 partial write at the top address
    drive1(0, 1, 13'h1FFF, 4'hF, 32'hFFFFFFFF);
    next_cycle();
    drive1(0, 1, 13'h1FFF, 4'h3, 32'h12345678);
    @(negedge clk);
    chk("be_ramBE", ram_byteenable, 4'h3);
    next_cycle();
    drive1(1, 0, 13'h1FFF, 4'hF, 32'h0);
    @(negedge clk);
    chk("top_addr", ram_address, 13'h1FFF);
    next_cycle();
    drive1(0, 0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("be_rdv1", m1_readdatavalid, 1);
    chk("be_data", m1_readdata, 32'hFFFF5678);
    chk("be_m0rdv", m0_readdatavalid, 0);
    chk("be_m0data", m0_readdata, 0);
    next_cycle();

    // fresh arbitration state, then sustained contention
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive0(1, 0, 13'h0100, 4'hF, 32'h0);
    drive1(1, 0, 13'h0200, 4'hF, 32'h0);
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      g = ((i % 8) < 4) ? 0 : 1;
      @(negedge clk);
      chk($sformatf("rr_wait0_%0d", i), m0_waitrequest, (g != 0));
      chk($sformatf("rr_wait1_%0d", i), m1_waitrequest, (g != 1));
      if (i > 0) begin
        chk($sformatf("rr_rdv0_%0d", i), m0_readdatavalid, (prev == 0));
        chk($sformatf("rr_rdv1_%0d", i), m1_readdatavalid, (prev == 1));
        chk($sformatf("rr_data_%0d", i), (prev == 0) ? m0_readdata : m1_readdata,
            (prev == 0) ? 32'hC0DE0100 : 32'hC0DE0200);
      end
      prev = g;
      next_cycle();
    end

    // freeze: read accepted just before still returns
    drive1(0, 0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("fz_pre_wait0", m0_waitrequest, 0);
    next_cycle();
    freeze = 1'b1;
    drive1(1, 0, 13'h0200, 4'hF, 32'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("fz_cs_%0d", j), ram_chipselect, 0);
      chk($sformatf("fz_wait0_%0d", j), m0_waitrequest, 1);
      chk($sformatf("fz_wait1_%0d", j), m1_waitrequest, 1);
      chk($sformatf("fz_rdv0_%0d", j), m0_readdatavalid, (j == 0));
      if (j == 0) chk("fz_data", m0_readdata, 32'hC0DE0100);
      next_cycle();
    end
    freeze = 1'b0;
    drive0(0, 0, 13'h0, 4'h0, 32'h0);
    drive1(0, 0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("fz_post_rdv0", m0_readdatavalid, 0);
    next_cycle();

    // reset the cycle after a read is accepted
    drive0(1, 0, 13'h0100, 4'hF, 32'h0);
    @(negedge clk);
    chk("rr_pre_wait0", m0_waitrequest, 0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdv0", m0_readdatavalid, 0);
    chk("rst_mid_wait0", m0_waitrequest, 1);
    chk("rst_mid_cs", ram_chipselect, 0);
    next_cycle();
    reset = 1'b0;
    drive1(1, 0, 13'h0200, 4'hF, 32'h0);
    @(negedge clk);
    chk("rel_owner", dut.owner, 0);
    chk("rel_run", dut.run, 0);
    chk("rel_wait0", m0_waitrequest, 0);
    chk("rel_wait1", m1_waitrequest, 1);
    next_cycle();

    // port 0 alone, 20 back-to-back reads
    drive1(0, 0, 13'h0, 4'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      drive0(1, 0, 13'h0300 + 13'(i), 4'hF, 32'h0);
      @(negedge clk);
      chk($sformatf("b2b_wait_%0d", i), m0_waitrequest, 0);
      if (i > 0) begin
        chk($sformatf("b2b_rdv_%0d", i), m0_readdatavalid, 1);
        chk($sformatf("b2b_data_%0d", i), m0_readdata, 32'hC0DE0300 + (i - 1));
      end
      next_cycle();
    end
    drive0(0, 0, 13'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("b2b_last_data", m0_readdata, 32'hC0DE0313);
    chk("run_sat", dut.run, 15);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/helen_onchip_arbiter.md
# helen_onchip_arbiter

Two-port arbiter that shares the single-port 8192 x 32 on-chip RAM between two Avalon-MM masters: port 0 is the Nios data master, port 1 is the telemetry/DMA master. It accepts one access per cycle and uses round-robin with a bounded burst length. It drives the RAM slave pins (address, byteenable, chipselect, write, writedata, clken) and returns read data with `readdatavalid` one cycle after acceptance. It sits in the Qsys system between the masters and the RAM instance.

## Interface
Parameters:
- `ADDR_W`, 13, word address width (8192 words)
- `DATA_W`, 32, data width; byte enables are `DATA_W/8`
- `BURST_MAX`, 4, max consecutive grants to one port while the other port is requesting (1..15)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `freeze`  in  1  when high, no new access is granted
- `mN_address`  in  ADDR_W  port N word address (N = 0, 1)
- `mN_byteenable`  in  4  port N byte lanes
- `mN_read`, `mN_write`  in  1  port N request; both high in one cycle is illegal, treated as write
- `mN_writedata`  in  DATA_W  port N write data
- `mN_waitrequest`  out  1  high = request not accepted this cycle
- `mN_readdata`  out  DATA_W  read data; valid only with `mN_readdatavalid`
- `mN_readdatavalid`  out  1  one-cycle strobe to the owner of the read
- `ram_address`  out  ADDR_W  to RAM `address`
- `ram_byteenable`  out  4  to RAM `byteenable`
- `ram_chipselect`  out  1  to RAM `chipselect`
- `ram_write`  out  1  to RAM `write`
- `ram_writedata`  out  DATA_W  to RAM `writedata`
- `ram_clken`  out  1  to RAM `clken`; tied high
- `ram_readdata`  in  DATA_W  from RAM `readdata`

## Operation
- Request: `reqN = mN_read | mN_write`. A grant is an accepted access: `mN_waitrequest = reqN & ~grantN`. A master holds its request stable while waitrequest is high.
- Arbitration state is `owner` (0/1) plus `run` (4-bit count of consecutive grants to `owner`).
- Grant rules, evaluated combinationally each cycle:
  - `freeze`: no grant.
  - Neither port requesting: no grant.
  - One port requesting: that port is granted.
  - Both requesting and `run < BURST_MAX`: `owner` is granted.
  - Both requesting and `run >= BURST_MAX`: the other port is granted.
- State update on a grant to port g:
  - If g == `owner`: `run <= run+1`, saturating at 15.
  - Otherwise: `owner <= g`, `run <= 1`.
  - With no grant, `owner` holds and `run` holds.
- RAM drive:
  - `ram_*` come from a combinational mux of the granted port.
  - `ram_chipselect = grant0|grant1`.
  - `ram_write` = granted port's write.
  - With no grant: address, byteenable and writedata are forced to 0 and chipselect/write to 0.
- Read return:
  - A granted read sets `rd_pend <= 1` and `rd_own <= g`.
  - Next cycle, `m[rd_own]_readdatavalid = 1` and `m[rd_own]_readdata = ram_readdata`.
  - The other port sees readdata 0.
  - Writes produce no readdatavalid.
- Back-to-back reads are supported: `rd_pend` and `rd_own` reload every cycle.
- `freeze` does not cancel a read accepted in the previous cycle; it still returns.
- Reset values: `owner`=0, `run`=0, `rd_pend`=0. All waitrequest outputs follow requests, so they are high on any request during reset. readdatavalid=0, readdata=0, `ram_*`=0 except `ram_clken`=1.
- Reset asserted mid-operation: a pending read is dropped with no readdatavalid, and no RAM write occurs while reset is high.

## Timing
- Grant is decided and the RAM access issued in the same cycle as the request: 0 wait states when uncontended.
- Read latency is 1 cycle from acceptance (RAM address registered, output unregistered).
- Write takes effect at the accepting clock edge.
- Worst-case wait for a continuously requesting port is `BURST_MAX` cycles.
- Sustained contention yields the pattern BURST_MAX grants to one port, then BURST_MAX to the other.
- Combinational path: `mN_read/write` -> `mN_waitrequest` and `ram_*`; no loop.

## Structure
- Shared package `helen_pkg`: `HELEN_RAM_ADDR_W=13`, `HELEN_RAM_DATA_W=32`, `HELEN_RAM_WORDS=8192`, and port-index constants `PORT_CPU=0`, `PORT_DMA=1`.
- One natural sub-module, `helen_rr_pick2`: combinational grant logic from (req0, req1, owner, run, BURST_MAX, freeze) -> (grant0, grant1).
- Top level holds the state registers, the RAM mux and the read-return pipeline.

## Test plan
- Port 0 writes 0xDEADBEEF to address 0x0010 (be=0xF), then reads 0x0010 -> zero waitrequest; `m0_readdatavalid` one cycle after the read with 0xDEADBEEF; m1 outputs stay 0.
- Both ports request continuous reads, BURST_MAX=4 -> grant sequence 0,0,0,0,1,1,1,1,0…; each readdatavalid lands on the correct port with that port's address data.
- Port 1 writes byteenable 0x3 with 0x12345678 over 0xFFFFFFFF at 0x1FFF -> later read returns 0xFFFF5678; the top address does not wrap.
- `freeze` high for 3 cycles while both request -> `ram_chipselect`=0 and both waitrequest=1 throughout; a read accepted the cycle before freeze still returns its data.
- Assert `reset` the cycle after port 0's read is accepted -> no readdatavalid; after release, `owner`=0 and `run`=0, and the first contended grant goes to port 0.
- Port 0 alone requests 20 reads -> all accepted back-to-back with zero waitrequest; `run` saturates at 15 without wrapping.
